// File: rtl/wb_lsu_bridge.sv
// Byte-addressed LSU port to word-only Wishbone RAM: sub-word stores become read-modify-write, loads are lane-extracted.
// Optional macro LSU_MISALIGN_ERR_EN: misaligned or reserved-size requests answer with resp_err instead of aligning down.
module wb_lsu_bridge #(
   parameter int ADDR_WIDTH     = 14,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] wb_adr_o,
   output logic [31:0]           wb_dat_o,
   output logic                  wb_we_o,
   output logic                  wb_stb_o,
   output logic                  wb_cyc_o,
   input  logic [31:0]           wb_dat_i,
   input  logic                  wb_ack_i,
   output logic [2:0]            dbg_state
);

   // Handshake: a request transfers on a cycle with req_valid && req_ready (IDLE only); fields are sampled
   // only then. resp_valid is a one-cycle pulse without back-pressure, resp_err/resp_rdata qualify it.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD    = 3'd1,
      S_MERGE = 3'd2,
      S_WR    = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   localparam int CW = $clog2(TIMEOUT_CYCLES);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] adr_q;
   logic [1:0]            size_q, off_q;
   logic                  we_q, uns_q, err_q;
   logic [31:0]           dat_q, rdata_q;
   logic [CW-1:0]         cnt_q;

   logic [1:0]  acc_size, acc_off;
   logic        misalign, timeout;
   logic [31:0] merged, shifted, load_data;
   logic        unused_addr;

   assign unused_addr = &{1'b0, req_addr[31:ADDR_WIDTH+2]};

   // Reserved size behaves as word; offsets are aligned down to the access size.
   always_comb begin
      acc_size = (req_size == 2'b11) ? 2'b10 : req_size;
      case (acc_size)
         2'b00:   acc_off = req_addr[1:0];
         2'b01:   acc_off = {req_addr[1], 1'b0};
         default: acc_off = 2'b00;
      endcase
   end

`ifdef LSU_MISALIGN_ERR_EN
   assign misalign = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      merged = rdata_q;
      case (size_q)
         2'b00:   merged[{off_q, 3'b000} +: 8]        = dat_q[7:0];
         2'b01:   merged[{off_q[1], 4'b0000} +: 16]   = dat_q[15:0];
         default: merged = dat_q;
      endcase
   end

   always_comb begin
      shifted = rdata_q >> {off_q, 3'b000};
      case (size_q)
         2'b00:   load_data = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
         2'b01:   load_data = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (misalign)                          state_d = S_RESP;
               else if (req_we && acc_size == 2'b10)  state_d = S_WR;
               else                                   state_d = S_RD;
            end
         end
         S_RD: begin
            if (wb_ack_i)     state_d = we_q ? S_MERGE : S_RESP;
            else if (timeout) state_d = S_RESP;
         end
         // One bus-idle cycle so the RAM's registered ack falls before the write strobe.
         S_MERGE: state_d = S_WR;
         S_WR: begin
            if (wb_ack_i || timeout) state_d = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         adr_q   <= '0;
         size_q  <= '0;
         off_q   <= '0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  adr_q  <= req_addr[ADDR_WIDTH+1:2];
                  size_q <= acc_size;
                  off_q  <= acc_off;
                  we_q   <= req_we;
                  uns_q  <= req_unsigned;
                  err_q  <= misalign;
                  dat_q  <= req_wdata;
                  cnt_q  <= '0;
               end
            end
            S_RD, S_WR: begin
               if (wb_ack_i) begin
                  cnt_q <= '0;
                  if (state_q == S_RD) rdata_q <= wb_dat_i;
               end else if (timeout) begin
                  cnt_q <= '0;
                  err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_MERGE: dat_q <= merged;
            default: ;
         endcase
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_err   = resp_valid & err_q;
   assign resp_rdata = (resp_valid && !we_q && !err_q) ? load_data : 32'h0;
   assign wb_stb_o   = (state_q == S_RD) || (state_q == S_WR);
   assign wb_cyc_o   = wb_stb_o;
   assign wb_we_o    = (state_q == S_WR);
   assign wb_adr_o   = adr_q;
   assign wb_dat_o   = dat_q;
   assign dbg_state  = state_q;

endmodule
